// File: rtl/bisection_ctrl.sv
// Wishbone control and result capture for the bisection core: holds coefficients,
// sequences the core out of reset, detects alpha convergence or timeout, captures the root.
module bisection_ctrl #(
  parameter logic [31:0] BASE_ADDR     = 32'h3000_0000,
  parameter int unsigned ALPHA_W       = 20,
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wbs_stb_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  output logic [15:0]        coef_o,
  output logic               core_rst_o,
  input  logic [ALPHA_W-1:0] alpha_i,
  output logic               irq_o
);

  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned SCNT_W = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] REG_COEF   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                ack_q, ack_d;
  logic [31:0]         dat_q, dat_d;
  logic [15:0]         coef_q, coef_d;
  logic                core_rst_q, core_rst_d;
  logic                irq_q, irq_d;
  logic                irq_en_q, irq_en_d;
  logic                done_q, done_d;
  logic                timeout_q, timeout_d;
  logic [ALPHA_W-1:0]  result_q, result_d;
  logic [ALPHA_W-1:0]  sample_q, sample_d;
  logic                first_q, first_d;
  logic [SCNT_W-1:0]   stable_q, stable_d;
  logic [CNT_W-1:0]    run_cnt_q, run_cnt_d;

  logic        req;
  logic        hit;
  logic        wr;
  logic        rd;
  logic        busy;
  logic        start;
  logic        equal;
  logic        conv;
  logic        tmo;
  logic [1:0]  idx;
  logic [31:0] rdata;
  logic        unused_bits;

  assign unused_bits = ^{wbs_adr_i[7:4], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

  // A request seen while ack is high is the tail of the previous transfer.
  assign req  = wbs_stb_i & wbs_cyc_i & ~ack_q;
  assign hit  = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign wr   = req & hit & wbs_we_i;
  assign rd   = req & hit & ~wbs_we_i;
  assign idx  = wbs_adr_i[3:2];
  assign busy = (state_q != IDLE);

  always_comb begin
    rdata = 32'h0;
    case (idx)
      REG_COEF:   rdata = {16'h0, coef_q};
      REG_CTRL:   rdata = {30'h0, irq_en_q, 1'b0};
      REG_STATUS: rdata = {29'h0, timeout_q, done_q, busy};
      REG_RESULT: rdata = 32'(result_q);
      default:    rdata = 32'h0;
    endcase
  end

  // Next-state logic: bus writes first, FSM set events afterwards so they win.
  always_comb begin
    state_d    = state_q;
    ack_d      = req;
    dat_d      = 32'h0;
    coef_d     = coef_q;
    core_rst_d = core_rst_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    timeout_d  = timeout_q;
    result_d   = result_q;
    sample_d   = sample_q;
    first_d    = first_q;
    stable_d   = stable_q;
    run_cnt_d  = run_cnt_q;
    start      = 1'b0;
    equal      = (alpha_i == sample_q);
    conv       = 1'b0;
    tmo        = 1'b0;

    if (rd) begin
      dat_d = rdata;
    end

    if (wr) begin
      case (idx)
        REG_COEF: begin
          if (!busy && wbs_sel_i[0]) coef_d[7:0]  = wbs_dat_i[7:0];
          if (!busy && wbs_sel_i[1]) coef_d[15:8] = wbs_dat_i[15:8];
        end
        REG_CTRL: begin
          if (wbs_sel_i[0]) begin
            irq_en_d = wbs_dat_i[1];
            start    = wbs_dat_i[0] & ~busy;
          end
        end
        REG_STATUS: begin
          if (wbs_sel_i[0] && wbs_dat_i[1]) done_d    = 1'b0;
          if (wbs_sel_i[0] && wbs_dat_i[2]) timeout_d = 1'b0;
        end
        default: ;
      endcase
    end

    case (state_q)
      IDLE: begin
        core_rst_d = 1'b1;
        if (start) begin
          state_d   = LOAD;
          done_d    = 1'b0;
          timeout_d = 1'b0;
        end
      end
      LOAD: begin
        state_d    = RUN;
        core_rst_d = 1'b0;
        first_d    = 1'b1;
        stable_d   = '0;
        run_cnt_d  = '0;
      end
      RUN: begin
        sample_d  = alpha_i;
        first_d   = 1'b0;
        run_cnt_d = (run_cnt_q == '1) ? run_cnt_q : run_cnt_q + CNT_W'(1);
        if (first_q || !equal) begin
          stable_d = '0;
        end else if (stable_q != '1) begin
          stable_d = stable_q + SCNT_W'(1);
        end
        conv = ~first_q & equal & (stable_q == SCNT_W'(STABLE_CYCLES - 1));
        tmo  = (run_cnt_q == CNT_W'(TIMEOUT - 1));
        if (conv) begin
          result_d   = alpha_i;
          done_d     = 1'b1;
          state_d    = IDLE;
          core_rst_d = 1'b1;
        end else if (tmo) begin
          result_d   = alpha_i;
          timeout_d  = 1'b1;
          state_d    = IDLE;
          core_rst_d = 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        core_rst_d = 1'b1;
      end
    endcase

    irq_d = irq_en_d & (done_d | timeout_d);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      dat_q      <= 32'h0;
      coef_q     <= 16'h0;
      core_rst_q <= 1'b1;
      irq_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      result_q   <= '0;
      sample_q   <= '0;
      first_q    <= 1'b0;
      stable_q   <= '0;
      run_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      coef_q     <= coef_d;
      core_rst_q <= core_rst_d;
      irq_q      <= irq_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      result_q   <= result_d;
      sample_q   <= sample_d;
      first_q    <= first_d;
      stable_q   <= stable_d;
      run_cnt_q  <= run_cnt_d;
    end
  end

  assign wbs_ack_o  = ack_q;
  assign wbs_dat_o  = dat_q;
  assign coef_o     = coef_q;
  assign core_rst_o = core_rst_q;
  assign irq_o      = irq_q;

endmodule

// File: tb/tb_bisection_ctrl.sv
// Directed bench for bisection_ctrl: register table plus convergence, timeout, busy and reset sequences.
module tb_bisection_ctrl;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_COEF = BASE + 32'h0;
  localparam logic [31:0] A_CTRL = BASE + 32'h4;
  localparam logic [31:0] A_STAT = BASE + 32'h8;
  localparam logic [31:0] A_RES  = BASE + 32'hC;
  localparam logic [31:0] A_OOR  = BASE + 32'h100;

  logic        clk;
  logic        reset;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] adr, dat;
  logic        ack_o;
  logic [31:0] dat_o;
  logic [15:0] coef;
  logic        core_rst;
  logic [19:0] alpha;
  logic        irq;

  logic [19:0] alpha_base;
  logic        tog_en;
  int          cycn;
  int          total;
  int          passed;

  // alpha model: constant, or inverted on every other edge so consecutive samples always differ.
  assign alpha = (tog_en && cycn[0]) ? ~alpha_base : alpha_base;

  bisection_ctrl #(
    .BASE_ADDR(BASE), .ALPHA_W(20), .STABLE_CYCLES(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack_o), .wbs_dat_o(dat_o),
    .coef_o(coef), .core_rst_o(core_rst), .alpha_i(alpha), .irq_o(irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycn <= cycn + 1;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic [15:0] exp_coef;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r, output logic k);
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk);
    #1;
    k = ack_o;
    r = dat_o;
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    logic        k;
    wb_xfer(1'b1, a, d, s, r, k);
    chk("wr_ack", 32'(k), 32'd1);
  endtask

  task automatic wb_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    logic        k;
    wb_xfer(1'b0, a, 32'h0, 4'hF, r, k);
    chk("rd_ack", 32'(k), 32'd1);
    chk(name, r, exp);
  endtask

  task automatic wait_rst(input logic val, input int budget);
    int n;
    n = 0;
    while (core_rst !== val && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_core_rst", 32'(core_rst), 32'(val));
  endtask

  initial begin
    logic [31:0] r;
    logic        k;
    logic [3:0]  pat;
    logic [19:0] exp_res;
    int          t0;

    total = 0; passed = 0; cycn = 0;
    reset = 1'b1; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = 4'h0;
    adr = 32'h0; dat = 32'h0; alpha_base = 20'h0; tog_en = 1'b0;

    vecs[0]  = '{1'b0, A_COEF, 32'h0,      4'hF, 1'b1, 32'h0,     16'h0000};
    vecs[1]  = '{1'b0, A_CTRL, 32'h0,      4'hF, 1'b1, 32'h0,     16'h0000};
    vecs[2]  = '{1'b0, A_STAT, 32'h0,      4'hF, 1'b1, 32'h0,     16'h0000};
    vecs[3]  = '{1'b0, A_RES,  32'h0,      4'hF, 1'b1, 32'h0,     16'h0000};
    vecs[4]  = '{1'b1, A_COEF, 32'hA5C3,   4'h1, 1'b0, 32'h0,     16'h00C3};
    vecs[5]  = '{1'b0, A_COEF, 32'h0,      4'hF, 1'b1, 32'h00C3,  16'h00C3};
    vecs[6]  = '{1'b1, A_COEF, 32'hA5C3,   4'h3, 1'b0, 32'h0,     16'hA5C3};
    vecs[7]  = '{1'b0, A_COEF, 32'h0,      4'hF, 1'b1, 32'hA5C3,  16'hA5C3};
    vecs[8]  = '{1'b1, A_COEF, 32'h1234,   4'h2, 1'b0, 32'h0,     16'h12C3};
    vecs[9]  = '{1'b1, A_OOR,  32'hFFFF,   4'hF, 1'b0, 32'h0,     16'h12C3};
    vecs[10] = '{1'b0, A_OOR,  32'h0,      4'hF, 1'b1, 32'h0,     16'h12C3};
    vecs[11] = '{1'b1, A_CTRL, 32'h2,      4'h0, 1'b0, 32'h0,     16'h12C3};
    vecs[12] = '{1'b0, A_CTRL, 32'h0,      4'hF, 1'b1, 32'h0,     16'h12C3};
    vecs[13] = '{1'b1, A_CTRL, 32'h2,      4'h1, 1'b0, 32'h0,     16'h12C3};
    vecs[14] = '{1'b0, A_CTRL, 32'h0,      4'hF, 1'b1, 32'h2,     16'h12C3};
    vecs[15] = '{1'b1, A_COEF, 32'hA5C3,   4'h3, 1'b0, 32'h0,     16'hA5C3};
    vecs[16] = '{1'b0, A_STAT, 32'h0,      4'hF, 1'b1, 32'h0,     16'hA5C3};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_coef", 32'(coef), 32'd0);
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_dat", dat_o, 32'd0);

    for (int i = 0; i < 17; i++) begin
      wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, r, k);
      chk($sformatf("vec%0d_ack", i), 32'(k), 32'd1);
      if (vecs[i].chk_rd) chk($sformatf("vec%0d_rd", i), r, vecs[i].exp_rd);
      chk($sformatf("vec%0d_coef", i), 32'(coef), 32'(vecs[i].exp_coef));
    end

    // Held request: ack on alternate edges only.
    @(negedge clk);
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = A_COEF; sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      pat[3-i] = ack_o;
    end
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    chk("ack_pattern", 32'(pat), 32'hA);

    // Convergence on a constant alpha.
    alpha_base = 20'h12345;
    wb_wr(A_CTRL, 32'h3, 4'h1);
    t0 = cycn;
    chk("load_busy_core_rst", 32'(core_rst), 32'd1);
    wait_rst(1'b0, 10);
    chk("run_entry_lat", 32'(cycn - t0), 32'd1);
    wait_rst(1'b1, 20);
    chk("conv_lat", 32'(cycn - t0), 32'd6);
    chk("conv_irq", 32'(irq), 32'd1);
    wb_rd("conv_status", A_STAT, 32'h2);
    wb_rd("conv_result", A_RES, 32'h12345);
    wb_wr(A_STAT, 32'h2, 4'h1);
    chk("w1c_irq", 32'(irq), 32'd0);
    wb_rd("w1c_status", A_STAT, 32'h0);

    // Toggling alpha: timeout, with COEF write and restart attempted while busy.
    alpha_base = 20'h0F0F0;
    tog_en = 1'b1;
    wb_wr(A_CTRL, 32'h3, 4'h1);
    t0 = cycn;
    exp_res = t0[0] ? ~alpha_base : alpha_base;
    wait_rst(1'b0, 10);
    wb_wr(A_COEF, 32'hFFFF, 4'h3);
    chk("busy_coef", 32'(coef), 32'hA5C3);
    wb_rd("busy_status", A_STAT, 32'h1);
    wb_wr(A_CTRL, 32'h3, 4'h1);
    wait_rst(1'b1, 40);
    chk("tmo_lat", 32'(cycn - t0), 32'd17);
    chk("tmo_irq", 32'(irq), 32'd1);
    wb_rd("tmo_status", A_STAT, 32'h4);
    wb_rd("tmo_result", A_RES, 32'(exp_res));
    wb_rd("tmo_coef_rd", A_COEF, 32'hA5C3);

    // Reset asserted in the middle of RUN.
    wb_wr(A_CTRL, 32'h3, 4'h1);
    wait_rst(1'b0, 10);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_core_rst", 32'(core_rst), 32'd1);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_coef", 32'(coef), 32'd0);
    chk("mid_rst_ack", 32'(ack_o), 32'd0);
    chk("mid_rst_dat", dat_o, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tog_en = 1'b0;
    wb_rd("post_rst_result", A_RES, 32'h0);
    wb_rd("post_rst_status", A_STAT, 32'h0);
    wb_rd("post_rst_ctrl", A_CTRL, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
